chaos_diffuser: RTL and testbench

- Sits directly downstream of the chaotic-value extractor. Consumes its three 0..999 fraction samples per extraction.
- Turns each sample into a key byte and buffers the bytes in a small key FIFO.
- Runs a chained XOR diffusion over a pixel byte stream: encrypt in one mode, decrypt in the other.
- Raises a single-cycle request to the extractor whenever the FIFO has room for another triple.

---
 rtl/chaos_diffuser_pkg.sv | 25 ++
 rtl/chaos_key_fifo.sv | 57 +++++
 rtl/chaos_diffuser.sv | 132 +++++++++++++
 tb/tb_chaos_diffuser.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_diffuser_pkg.sv
// Shared types and constants for the chaotic key diffuser: key width, default IV,
// mode encodings and the reduction of an extractor sample to a key byte.
package chaos_diffuser_pkg;

    localparam int unsigned EX_W_DEF = 23;
    localparam int unsigned KEY_W    = 8;
    localparam logic [KEY_W-1:0] IV_DEF = 8'hA5;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // One extraction worth of key bytes; k0 is pushed first
    typedef struct packed {
        logic [KEY_W-1:0] k2;
        logic [KEY_W-1:0] k1;
        logic [KEY_W-1:0] k0;
    } key_triple_t;

    function automatic logic [KEY_W-1:0] sample_to_key(input logic [EX_W_DEF-1:0] s);
        return s[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/chaos_key_fifo.sv
// Key byte FIFO: three bytes pushed per extraction, one popped per pixel.
// A push that does not fit is rejected whole and reported on o_reject_c.
module chaos_key_fifo
    import chaos_diffuser_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  key_triple_t       i_triple,
    input  logic              i_pop,
    output logic [KEY_W-1:0]  o_head_c,
    output logic [CW-1:0]     o_count,
    output logic [CW-1:0]     o_free_c,
    output logic              o_reject_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [KEY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Room is judged on the pre-pop count
    assign o_free_c   = CW'(DEPTH) - r_count;
    assign w_push_ok  = i_push && (o_free_c >= CW'(3));
    assign o_reject_c = i_push && !w_push_ok;
    assign w_pop_ok   = i_pop && (r_count != '0);
    assign o_head_c   = r_mem[r_rd];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr]          <= i_triple.k0;
            r_mem[r_wr + AW'(1)] <= i_triple.k1;
            r_mem[r_wr + AW'(2)] <= i_triple.k2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(3);
            if (w_pop_ok)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (w_push_ok ? CW'(3) : CW'(0)) - (w_pop_ok ? CW'(1) : CW'(0));
        end
    end

endmodule

// File: rtl/chaos_diffuser.sv
// Chained XOR diffusion of a pixel byte stream keyed by chaotic extractor samples;
// requests a new sample triple whenever the key FIFO can hold one.
module chaos_diffuser
    import chaos_diffuser_pkg::*;
#(
    parameter int unsigned      KEY_DEPTH = 8,
    parameter logic [KEY_W-1:0] IV        = IV_DEF,
    parameter int unsigned      EX_W      = EX_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    output logic             o_key_req,
    input  logic             i_valid_extract,
    input  logic [EX_W-1:0]  i_ex1,
    input  logic [EX_W-1:0]  i_ex2,
    input  logic [EX_W-1:0]  i_ex3,
    input  logic             i_mode,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic [7:0]       i_pix_data,
    input  logic             i_pix_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data,
    output logic             o_out_last,
    output logic             o_err_overflow
);

    localparam int unsigned CW = $clog2(KEY_DEPTH) + 1;

    key_triple_t      w_triple;
    logic [KEY_W-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;
    logic             w_reject;
    logic             w_push;
    logic             w_req;
    logic             w_accept;
    mode_e            w_mode;
    logic [7:0]       w_out_byte;
    logic [7:0]       w_next_chain;

    logic             r_key_req;
    logic             r_outstanding;
    logic             r_err;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_last;
    logic [7:0]       r_chain;
    logic             r_frame_start;
    mode_e            r_mode;

    assign w_triple = '{k2: sample_to_key(EX_W_DEF'(i_ex3)),
                        k1: sample_to_key(EX_W_DEF'(i_ex2)),
                        k0: sample_to_key(EX_W_DEF'(i_ex1))};

    // Unsolicited triples never reach the FIFO
    assign w_push = i_valid_extract && r_outstanding;
    assign w_req  = i_enable && !r_outstanding && (w_free >= CW'(3));

    chaos_key_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_triple   (w_triple),
        .i_pop      (w_accept),
        .o_head_c   (w_head),
        .o_count    (w_count),
        .o_free_c   (w_free),
        .o_reject_c (w_reject)
    );

    assign o_pix_ready = (w_count != '0) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_pix_valid && o_pix_ready;
    assign w_mode      = r_frame_start ? mode_e'(i_mode) : r_mode;
    assign w_out_byte  = i_pix_data ^ w_head ^ r_chain;

    // Encrypt chains on the produced ciphertext, decrypt on the consumed one
    always_comb begin
        w_next_chain = r_chain;
        if (i_pix_last)
            w_next_chain = IV;
        else if (w_mode == MODE_DEC)
            w_next_chain = i_pix_data;
        else
            w_next_chain = w_out_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_req     <= 1'b0;
            r_outstanding <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_key_req <= w_req;
            if (w_req)
                r_outstanding <= 1'b1;
            else if (i_valid_extract)
                r_outstanding <= 1'b0;
            if ((i_valid_extract && !r_outstanding) || w_reject)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_chain       <= IV;
            r_frame_start <= 1'b1;
            r_mode        <= MODE_ENC;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_out_byte;
            r_out_last    <= i_pix_last;
            r_chain       <= w_next_chain;
            r_frame_start <= i_pix_last;
            r_mode        <= w_mode;
        end else if (i_out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign o_key_req      = r_key_req;
    assign o_err_overflow = r_err;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_out_last     = r_out_last;

endmodule

// File: tb/tb_chaos_diffuser.sv
// Bench for chaos_diffuser: a queue-based model checked every cycle, plus
// hand-computed byte sequences for the encrypt/decrypt/backpressure/overflow/reset cases.
module tb_chaos_diffuser;

    localparam int DEPTH = 8;
    localparam logic [7:0] IVV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_enable = 1'b1;
    logic        o_key_req;
    logic        i_valid_extract = 1'b0;
    logic [22:0] i_ex1 = '0, i_ex2 = '0, i_ex3 = '0;
    logic        i_mode = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_ready;
    logic [7:0]  i_pix_data = '0;
    logic        i_pix_last = 1'b0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic [7:0]  o_out_data;
    logic        o_out_last;
    logic        o_err_overflow;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;

    // Model state
    logic [7:0] m_keys[$];
    logic [8:0] m_exp[$];
    logic [8:0] got_q[$];
    bit         m_out = 0, m_err = 0, m_req = 0, m_fs = 1, m_mode = 0;
    logic [7:0] m_chain = IVV;

    always #5 clk = ~clk;

    chaos_diffuser #(.KEY_DEPTH(DEPTH), .IV(IVV), .EX_W(23)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_enable       (i_enable),
        .o_key_req      (o_key_req),
        .i_valid_extract(i_valid_extract),
        .i_ex1          (i_ex1),
        .i_ex2          (i_ex2),
        .i_ex3          (i_ex3),
        .i_mode         (i_mode),
        .i_pix_valid    (i_pix_valid),
        .o_pix_ready    (o_pix_ready),
        .i_pix_data     (i_pix_data),
        .i_pix_last     (i_pix_last),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_data     (o_out_data),
        .o_out_last     (o_out_last),
        .o_err_overflow (o_err_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by the coming edge
    always @(negedge clk) begin
        bit ready, acc, push_ok, req_n, md;
        int cnt;
        logic [7:0] k, o;
        if (!reset_n) begin
            check("rst_key_req", o_key_req, 0);
            check("rst_out_valid", o_out_valid, 0);
            check("rst_out_data", o_out_data, 0);
            check("rst_out_last", o_out_last, 0);
            check("rst_err", o_err_overflow, 0);
            m_keys.delete();
            m_exp.delete();
            m_out = 0; m_err = 0; m_req = 0; m_fs = 1; m_mode = 0; m_chain = IVV;
        end else begin
            cnt = m_keys.size();
            ready = (cnt != 0) && (m_exp.size() == 0 || i_out_ready);
            check("key_req", o_key_req, m_req);
            check("err_overflow", o_err_overflow, m_err);
            check("out_valid", o_out_valid, m_exp.size() != 0);
            check("pix_ready", o_pix_ready, ready);
            if (m_exp.size() != 0)
                check("out_byte", {o_out_last, o_out_data}, m_exp[0]);
            if (o_key_req) req_cnt++;
            if (o_out_valid && i_out_ready) got_q.push_back({o_out_last, o_out_data});
            if (m_exp.size() != 0 && i_out_ready) void'(m_exp.pop_front());
            acc = i_pix_valid && ready;
            if (acc) begin
                md = m_fs ? i_mode : m_mode;
                k = m_keys.pop_front();
                o = i_pix_data ^ k ^ m_chain;
                m_exp.push_back({i_pix_last, o});
                if (i_pix_last) begin
                    m_chain = IVV; m_fs = 1;
                end else begin
                    m_chain = md ? i_pix_data : o; m_fs = 0;
                end
                m_mode = md;
            end
            push_ok = i_valid_extract && m_out && (DEPTH - cnt >= 3);
            if (i_valid_extract && !push_ok) m_err = 1;
            if (push_ok) begin
                m_keys.push_back(8'(i_ex1 % 23'd256));
                m_keys.push_back(8'(i_ex2 % 23'd256));
                m_keys.push_back(8'(i_ex3 % 23'd256));
            end
            req_n = i_enable && !m_out && (DEPTH - cnt >= 3);
            if (req_n) m_out = 1;
            else if (i_valid_extract) m_out = 0;
            m_req = req_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int e1, input int e2, input int e3);
        i_ex1 = 23'(e1); i_ex2 = 23'(e2); i_ex3 = 23'(e3);
        i_valid_extract = 1'b1;
        tick();
        i_valid_extract = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit md);
        bit done = 0;
        i_pix_valid = 1'b1; i_pix_data = d; i_pix_last = last; i_mode = md;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (o_pix_ready) done = 1;
        end
        check("pix_accept", done, 1);
        tick();
        i_pix_valid = 1'b0; i_pix_last = 1'b0;
    endtask

    task automatic expect_got(input string name, input int n,
                              input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
        logic [8:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check(name, got_q[i], e[i]);
        got_q.delete();
    endtask

    initial begin
        int r0;
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int r0;
        // Reset release: one request, not repeated while outstanding
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) tick();
        check("t1_req_pulses", req_cnt, 1);
        check("t1_err", o_err_overflow, 0);

        // Encrypt 11 22 33 with keys 2C E7 00
        respond(300, 999, 256);
        got_q.delete();
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 1, 0);
        repeat (3) tick();
        expect_got("t2_enc", 3, 9'h098, 9'h05D, 9'h16E);

        // Decrypt, with mode flipped after the first byte
        respond(300, 999, 256);
        send_byte(8'h98, 0, 1);
        send_byte(8'h5D, 0, 0);
        send_byte(8'h6E, 1, 0);
        repeat (3) tick();
        expect_got("t3_dec", 3, 9'h011, 9'h022, 9'h133);

        // Output backpressure for several cycles
        respond(300, 999, 256);
        fork
            begin
                send_byte(8'h01, 0, 0);
                send_byte(8'h02, 0, 0);
                send_byte(8'h03, 1, 0);
            end
            begin
                i_out_ready = 1'b0;
                repeat (6) tick();
                i_out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        expect_got("t4_stall", 3, 9'h088, 9'h06D, 9'h16E);

        // Fill to 6: no third request until one key is popped
        respond(1, 2, 3);
        repeat (3) tick();
        respond(4, 5, 6);
        repeat (2) tick();
        r0 = req_cnt;
        repeat (10) tick();
        check("t5_no_req", req_cnt - r0, 0);
        check("t5_req_total", req_cnt, 5);
        send_byte(8'h00, 1, 0);
        repeat (3) tick();
        check("t5_req_after_pop", req_cnt, 6);
        expect_got("t5_byte", 1, 9'h1A4, 9'h000, 9'h000);

        // Fill to 8, then inject an unsolicited triple
        respond(7, 8, 9);
        repeat (2) tick();
        respond(10, 11, 12);
        repeat (2) tick();
        check("t6_err_set", o_err_overflow, 1);
        check("t6_no_req", req_cnt, 6);
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 1, 0);
        repeat (3) tick();
        expect_got("t6_keys_intact", 2, 9'h0A7, 9'h1A4, 9'h000);
        check("t6_err_sticky", o_err_overflow, 1);

        // Reset mid-frame; next frame restarts from IV
        send_byte(8'h10, 0, 0);
        reset_n = 1'b0;
        repeat (3) tick();
        check("t6_rst_err", o_err_overflow, 0);
        got_q.delete();
        reset_n = 1'b1;
        repeat (3) tick();
        respond(300, 999, 256);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 1, 0);
        repeat (3) tick();
        expect_got("t6_after_rst", 3, 9'h098, 9'h05D, 9'h16E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
